// File: rtl/adam_stream_fifo_if.sv
// Valid/ready stream bundle shared by both sides of the stream FIFO.
// The FIFO takes one instance as slave (input side) and one as master (output side).
interface adam_stream_fifo_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/adam_stream_fifo.sv
// First-word-fall-through stream FIFO with registered valid/ready on both sides.
// Handshake outputs are decoded from the registered count only, so there are no input-to-output combinational paths.
module adam_stream_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   adam_stream_fifo_if.slave    slv,
   adam_stream_fifo_if.master   mst,
   output logic [CNT_WIDTH-1:0] count
);
   localparam int                   PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0]     LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] FULL  = CNT_WIDTH'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  not_full, not_empty;
   logic                  push, pop;

   assign not_full  = (count_q != FULL);
   assign not_empty = (count_q != '0);
   assign push      = slv.valid & not_full;
   assign pop       = mst.ready & not_empty;

   assign slv.ready = not_full;
   assign mst.valid = not_empty;
   assign mst.data  = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Explicit wrap compare keeps non-power-of-two depths working.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; its contents are only observed while valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= slv.data;
   end

`ifndef SYNTHESIS
   a_count_range: assert property (@(posedge clk) disable iff (!rst) count_q <= FULL);
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && count_q == '0));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && count_q == FULL));
`endif
endmodule

// File: doc/adam_stream_fifo.md
Name: adam_stream_fifo

Overview:
- Synchronous first-word-fall-through stream FIFO, DEPTH entries deep, with valid/ready handshakes on both sides.
- Sits directly upstream of adam_stream_skid. It absorbs producer bursts and presents a registered valid/data stream that the skid stage consumes.
- Both ports follow the codebase stream contract: a transfer occurs on the rising clk edge where valid and ready are both high.

Parameters:
- DATA_WIDTH, 32, width of the data payload in bits.
- DEPTH, 4, number of storage entries; legal range 2..256, need not be a power of two.
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy output (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- slv_data  in  DATA_WIDTH  write payload.
- slv_valid  in  1  producer has data.
- slv_ready  out  1  FIFO accepts data this cycle.
- mst_data  out  DATA_WIDTH  head-of-queue payload.
- mst_valid  out  1  head entry is valid.
- mst_ready  in  1  consumer (skid stage) accepts.
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous release):
  - rd_ptr, wr_ptr and count are cleared to 0.
  - mst_valid = 0 and slv_ready = 1 during reset and in the first cycle after release.
  - Storage contents are not reset. mst_data is don't-care while mst_valid = 0.
- Push = slv_valid & slv_ready. Pop = mst_valid & mst_ready.
- Output signals:
  - slv_ready = (count != DEPTH). It is a function of registered count only and has no combinational path from mst_ready.
  - mst_valid = (count != 0). It is a function of registered count only and has no combinational path from slv_valid.
  - mst_data = mem[rd_ptr] (first-word fall-through).
- Latency: a word pushed at edge N is visible on mst_data/mst_valid after edge N, so it can be popped at edge N+1 at the earliest. There is no same-cycle bypass from slv to mst.
- Pointers:
  - wr_ptr advances on push and rd_ptr advances on pop.
  - Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by bit truncation, so non-power-of-two DEPTH is supported.
- Count update:
  - count +1 on push only.
  - count -1 on pop only.
  - count unchanged on simultaneous push and pop, or when neither occurs.
- Full (count == DEPTH):
  - slv_ready = 0, so no push occurs regardless of slv_valid.
  - A pop in this cycle makes slv_ready = 1 in the next cycle. Full pass-through is not required.
- Empty (count == 0):
  - mst_valid = 0, so no pop occurs.
  - A simultaneous push is allowed and count becomes 1.
- Simultaneous push and pop with 0 < count < DEPTH:
  - Both pointers advance and count is unchanged.
  - Memory write and read target different entries, so there is no read-during-write hazard.
- Ordering: strict FIFO. No beat is dropped or duplicated.
- Producer obligation: slv_data must be held stable while slv_valid is high and slv_ready is low. The FIFO does not check this.
- Reset asserted mid-operation:
  - All queued data is discarded.
  - mst_valid drops immediately (asynchronously).
  - After release the FIFO behaves as freshly reset.
- Assertions (bhv only):
  - count never exceeds DEPTH.
  - No pop when count == 0.
  - No push when count == DEPTH.

Test Plan:
- Basic: after reset release, push 0xA5A5A5A5 in one cycle with mst_ready = 1 -> mst_valid rises one cycle after the push, data = 0xA5A5A5A5, count goes 0 -> 1 -> 0.
- Fill/stall: with mst_ready = 0, push 1, 2, 3, 4 (DEPTH = 4) -> count = 4, slv_ready = 0. A 5th push attempt is held with no transfer. Then set mst_ready = 1 -> pops return 1, 2, 3, 4 in order, and slv_ready returns high the cycle after the first pop.
- Streaming: slv_valid = mst_ready = 1 for 100 cycles with incrementing data -> one beat per cycle after the first, count stays 1, and output order matches input.
- Wrap: with DEPTH = 3, push and pop 10 words through random stalls -> all 10 words are received in order, exercising pointer wrap at entry 2.
- Random backpressure: 1000 beats with random slv_valid/mst_ready at 50% -> scoreboard matches, and count equals pushes minus pops every cycle.
- Reset mid-operation: push 3 words, then pulse rst low for 1 cycle -> mst_valid = 0 and count = 0 immediately, slv_ready = 1, and the next pushed word 0x55 is the first word popped.
